// File: rtl/bomb_game_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bomb_game_ctrl_pkg
// Shared definitions for the bomb puzzle game sequencer and for every module
// that decodes the game_state bus.
//   - GS_* : game_state bus encodings (the one place they are defined)
//   - TIME_*_DEFAULT : BCD countdown start times per difficulty
//   - game_fsm_t : sequencer state enum
//   - diff_to_time : difficulty select to initial time mapping
// ---------------------------------------------------------------------------
package bomb_game_ctrl_pkg;

    localparam logic [7:0] GS_IDLE     = 8'h00;
    localparam logic [7:0] GS_ACTIVE   = 8'h10;
    localparam logic [7:0] GS_DEFUSED  = 8'h20;
    localparam logic [7:0] GS_EXPLODED = 8'h30;

    localparam logic [11:0] TIME_EASY_DEFAULT = 12'h300;
    localparam logic [11:0] TIME_MED_DEFAULT  = 12'h200;
    localparam logic [11:0] TIME_HARD_DEFAULT = 12'h090;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_DEFUSED  = 2'd2,
        ST_EXPLODED = 2'd3
    } game_fsm_t;

    // Difficulty 0 -> easy, 1 -> medium, 2 and 3 -> hard.
    function automatic logic [11:0] diff_to_time(
        input logic [1:0]  difficulty,
        input logic [11:0] t_easy,
        input logic [11:0] t_med,
        input logic [11:0] t_hard
    );
        case (difficulty)
            2'd0:    return t_easy;
            2'd1:    return t_med;
            default: return t_hard;
        endcase
    endfunction

endpackage

// File: rtl/bomb_game_ctrl_strike_counter.sv
// ---------------------------------------------------------------------------
// bomb_game_ctrl_strike_counter
// Saturating strike accumulator. Counts the set bits of the (already masked)
// strike vector each enabled cycle and adds them to the running count,
// saturating at MAX_STRIKES.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   strike_masked   : strike pulses from modules in play
//   clear           : zero the count (takes priority over enable)
//   enable          : accumulate this cycle (game active)
//   strike_count    : registered saturating count
//   strike_flash    : registered, high for one cycle per accepted strike cycle
//   at_max          : combinational, this cycle's accumulated sum reaches max
// ---------------------------------------------------------------------------
module bomb_game_ctrl_strike_counter #(
    parameter int N_MOD       = 4,
    parameter int MAX_STRIKES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_MOD-1:0] strike_masked,
    input  logic             clear,
    input  logic             enable,
    output logic [1:0]       strike_count,
    output logic             strike_flash,
    output logic             at_max
);

    // Wide enough for (max count 3) + (all N_MOD strikes at once).
    localparam int CW = $clog2(N_MOD + 4);

    logic [CW-1:0] pc [0:N_MOD];
    logic [CW-1:0] sum;
    logic [1:0]    sat_sum;
    logic [1:0]    count_reg;
    logic          flash_reg;

    // Ripple popcount of the masked strike vector.
    assign pc[0] = '0;
    generate
        for (genvar gi = 0; gi < N_MOD; gi++) begin : g_popcount
            assign pc[gi+1] = pc[gi] + {{(CW-1){1'b0}}, strike_masked[gi]};
        end
    endgenerate

    assign sum     = {{(CW-2){1'b0}}, count_reg} + pc[N_MOD];
    assign sat_sum = (sum >= CW'(MAX_STRIKES)) ? 2'(MAX_STRIKES) : sum[1:0];
    assign at_max  = enable && (sum >= CW'(MAX_STRIKES));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= 2'd0;
            flash_reg <= 1'b0;
        end else if (enable) begin
            count_reg <= sat_sum;
            flash_reg <= (pc[N_MOD] != '0);
        end else begin
            flash_reg <= 1'b0;
        end
    end

    assign strike_count = count_reg;
    assign strike_flash = flash_reg;

endmodule

// File: rtl/bomb_game_ctrl.sv
// ---------------------------------------------------------------------------
// bomb_game_ctrl
// Top-level game sequencer for the bomb puzzle. Drives game_state for the
// countdown and puzzle modules, selects the countdown start time from the
// difficulty, aggregates solved/strike flags and decides win or explosion.
// Ports:
//   clk, reset            : 50 MHz clock, synchronous active-high reset
//   start                 : one-cycle start pulse
//   difficulty, module_en : sampled on start in IDLE
//   module_solved         : per-module solved level flags
//   strike                : per-module one-cycle strike pulses
//   sec_timer             : one-second pulse shared with the countdown
//   value_three/two/one   : countdown BCD digits (only tested for all zero)
//   game_state            : 00 idle, 10 active, 20 defused, 30 exploded
//   init_time             : BCD start time for the countdown
//   strike_count          : saturating strike count
//   strike_flash          : pulse per cycle with an accepted strike
// ---------------------------------------------------------------------------
module bomb_game_ctrl
    import bomb_game_ctrl_pkg::*;
#(
    parameter int          N_MOD       = 4,
    parameter int          MAX_STRIKES = 3,
    parameter logic [11:0] TIME_EASY   = TIME_EASY_DEFAULT,
    parameter logic [11:0] TIME_MED    = TIME_MED_DEFAULT,
    parameter logic [11:0] TIME_HARD   = TIME_HARD_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       difficulty,
    input  logic [N_MOD-1:0] module_en,
    input  logic [N_MOD-1:0] module_solved,
    input  logic [N_MOD-1:0] strike,
    input  logic             sec_timer,
    input  logic [3:0]       value_three,
    input  logic [3:0]       value_two,
    input  logic [3:0]       value_one,
    output logic [7:0]       game_state,
    output logic [11:0]      init_time,
    output logic [1:0]       strike_count,
    output logic             strike_flash
);

    game_fsm_t        state_reg, state_next;
    logic [11:0]      init_time_reg, init_time_next;
    logic [N_MOD-1:0] en_q_reg, en_q_next;
    logic             first_cycle_reg, first_cycle_next;
    logic             clear_strikes;
    logic             at_max;
    logic             expire;
    logic             win;
    logic             is_active;

    assign is_active = (state_reg == ST_ACTIVE);

    // The countdown still shows its old value during the first active cycle,
    // so an all-zero display then is not a real expiry.
    assign expire = sec_timer && !first_cycle_reg &&
                    (value_three == 4'd0) && (value_two == 4'd0) &&
                    (value_one == 4'd0);

    assign win = ((module_solved & en_q_reg) == en_q_reg);

    bomb_game_ctrl_strike_counter #(
        .N_MOD       (N_MOD),
        .MAX_STRIKES (MAX_STRIKES)
    ) u_strike_counter (
        .clk           (clk),
        .reset         (reset),
        .strike_masked (strike & en_q_reg),
        .clear         (clear_strikes),
        .enable        (is_active),
        .strike_count  (strike_count),
        .strike_flash  (strike_flash),
        .at_max        (at_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            init_time_reg   <= TIME_EASY;
            en_q_reg        <= '1;
            first_cycle_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            init_time_reg   <= init_time_next;
            en_q_reg        <= en_q_next;
            first_cycle_reg <= first_cycle_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        init_time_next   = init_time_reg;
        en_q_next        = en_q_reg;
        first_cycle_next = 1'b0;
        clear_strikes    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    // An empty selection would be an instant win; play all.
                    en_q_next        = (module_en == '0) ? '1 : module_en;
                    init_time_next   = diff_to_time(difficulty, TIME_EASY,
                                                    TIME_MED, TIME_HARD);
                    clear_strikes    = 1'b1;
                    first_cycle_next = 1'b1;
                    state_next       = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // Explosion wins ties with a simultaneous final solve.
                if (expire || at_max) begin
                    state_next = ST_EXPLODED;
                end else if (win) begin
                    state_next = ST_DEFUSED;
                end
            end
            ST_DEFUSED, ST_EXPLODED: begin
                if (start) begin
                    clear_strikes = 1'b1;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                clear_strikes = 1'b1;
                state_next    = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        game_state = GS_IDLE;
        case (state_reg)
            ST_ACTIVE:   game_state = GS_ACTIVE;
            ST_DEFUSED:  game_state = GS_DEFUSED;
            ST_EXPLODED: game_state = GS_EXPLODED;
            default:     game_state = GS_IDLE;
        endcase
    end

    assign init_time = init_time_reg;

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bomb_game_ctrl
// Directed bench: each step drives inputs, pushes the outputs expected after
// the next rising edge, then pops and compares them 1 time unit after it.
// ---------------------------------------------------------------------------
module tb_bomb_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] difficulty;
    logic [3:0] module_en;
    logic [3:0] module_solved;
    logic [3:0] strike;
    logic       sec_timer;
    logic [3:0] value_three, value_two, value_one;
    logic [7:0] game_state;
    logic [11:0] init_time;
    logic [1:0] strike_count;
    logic       strike_flash;

    int errors = 0;
    int checks = 0;
    int flash_cycles = 0;

    typedef struct {
        string       tag;
        logic [7:0]  gs;
        logic [1:0]  sc;
        logic        fl;
        logic [11:0] it;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    bomb_game_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .difficulty    (difficulty),
        .module_en     (module_en),
        .module_solved (module_solved),
        .strike        (strike),
        .sec_timer     (sec_timer),
        .value_three   (value_three),
        .value_two     (value_two),
        .value_one     (value_one),
        .game_state    (game_state),
        .init_time     (init_time),
        .strike_count  (strike_count),
        .strike_flash  (strike_flash)
    );

    // Flash pulse counter, sampled away from the active edge.
    always @(negedge clk) begin
        if (strike_flash) flash_cycles++;
    end

    task automatic push_exp(input string tag, input logic [7:0] gs,
                            input logic [1:0] sc, input logic fl,
                            input logic [11:0] it);
        exp_t e;
        e.tag = tag; e.gs = gs; e.sc = sc; e.fl = fl; e.it = it;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (game_state === e.gs) else begin
                errors++;
                $error("FAIL %s game_state got %h want %h", e.tag, game_state, e.gs);
            end
            checks++;
            assert (strike_count === e.sc) else begin
                errors++;
                $error("FAIL %s strike_count got %0d want %0d", e.tag, strike_count, e.sc);
            end
            checks++;
            assert (strike_flash === e.fl) else begin
                errors++;
                $error("FAIL %s strike_flash got %b want %b", e.tag, strike_flash, e.fl);
            end
            checks++;
            assert (init_time === e.it) else begin
                errors++;
                $error("FAIL %s init_time got %h want %h", e.tag, init_time, e.it);
            end
            $display("step %-12s gs=%h sc=%0d fl=%b it=%h", e.tag, game_state,
                     strike_count, strike_flash, init_time);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; difficulty = 2'd0; module_en = 4'b0;
        module_solved = 4'b0; strike = 4'b0; sec_timer = 1'b0;
        value_three = 4'd9; value_two = 4'd9; value_one = 4'd9;

        // Reset state
        push_exp("rst", 8'h00, 2'd0, 1'b0, 12'h300); tick();
        reset = 1'b0;
        push_exp("idle", 8'h00, 2'd0, 1'b0, 12'h300); tick();

        // Medium game, two modules, defuse
        start = 1'b1; difficulty = 2'd1; module_en = 4'b0011;
        push_exp("t1_start", 8'h10, 2'd0, 1'b0, 12'h200); tick();
        start = 1'b0; module_solved = 4'b0011;
        push_exp("t1_win", 8'h20, 2'd0, 1'b0, 12'h200); tick();
        strike = 4'b0001; sec_timer = 1'b1;
        push_exp("t1_hold", 8'h20, 2'd0, 1'b0, 12'h200); tick();
        strike = 4'b0000; sec_timer = 1'b0; start = 1'b1;
        push_exp("t1_idle", 8'h00, 2'd0, 1'b0, 12'h200); tick();
        start = 1'b0; module_solved = 4'b0000;

        // Easy game, three strikes explode
        start = 1'b1; difficulty = 2'd0; module_en = 4'b1111;
        push_exp("t2_start", 8'h10, 2'd0, 1'b0, 12'h300); tick();
        start = 1'b0; flash_cycles = 0;
        strike = 4'b0001; push_exp("t2_s1", 8'h10, 2'd1, 1'b1, 12'h300); tick();
        strike = 4'b0000; push_exp("t2_gap1", 8'h10, 2'd1, 1'b0, 12'h300); tick();
        strike = 4'b0001; push_exp("t2_s2", 8'h10, 2'd2, 1'b1, 12'h300); tick();
        strike = 4'b0000; push_exp("t2_gap2", 8'h10, 2'd2, 1'b0, 12'h300); tick();
        strike = 4'b0001; push_exp("t2_s3", 8'h30, 2'd3, 1'b1, 12'h300); tick();
        strike = 4'b0000; push_exp("t2_boom", 8'h30, 2'd3, 1'b0, 12'h300); tick();
        checks++;
        assert (flash_cycles == 3) else begin
            errors++;
            $error("FAIL t2_flash_cycles got %0d want 3", flash_cycles);
        end
        start = 1'b1; push_exp("t2_idle", 8'h00, 2'd0, 1'b0, 12'h300); tick();
        start = 1'b0;

        // Hard game, masked multi-strike, then reset mid-game
        start = 1'b1; difficulty = 2'd2; module_en = 4'b0101;
        push_exp("t3_start", 8'h10, 2'd0, 1'b0, 12'h090); tick();
        start = 1'b0;
        strike = 4'b1101; push_exp("t3_multi", 8'h10, 2'd2, 1'b1, 12'h090); tick();
        strike = 4'b1000; push_exp("t3_masked", 8'h10, 2'd2, 1'b0, 12'h090); tick();
        strike = 4'b0001; reset = 1'b1;
        push_exp("t3_reset", 8'h00, 2'd0, 1'b0, 12'h300); tick();
        strike = 4'b0000; reset = 1'b0;

        // Difficulty 3, empty enable mask, expiry gating and tie
        start = 1'b1; difficulty = 2'd3; module_en = 4'b0000;
        push_exp("t4_start", 8'h10, 2'd0, 1'b0, 12'h090); tick();
        start = 1'b0;
        value_three = 4'd0; value_two = 4'd0; value_one = 4'd0; sec_timer = 1'b1;
        push_exp("t4_first", 8'h10, 2'd0, 1'b0, 12'h090); tick();
        sec_timer = 1'b0; module_solved = 4'b0111; start = 1'b1;
        push_exp("t4_partial", 8'h10, 2'd0, 1'b0, 12'h090); tick();
        start = 1'b0; module_solved = 4'b1111; sec_timer = 1'b1;
        push_exp("t4_tie", 8'h30, 2'd0, 1'b0, 12'h090); tick();
        sec_timer = 1'b0; module_solved = 4'b0000;
        value_three = 4'd9; value_two = 4'd9; value_one = 4'd9;
        start = 1'b1; push_exp("t4_idle", 8'h00, 2'd0, 1'b0, 12'h090); tick();
        difficulty = 2'd1; module_en = 4'b0011;
        push_exp("t4_replay", 8'h10, 2'd0, 1'b0, 12'h200); tick();
        start = 1'b0; sec_timer = 1'b1;
        push_exp("t4_nonzero", 8'h10, 2'd0, 1'b0, 12'h200); tick();
        sec_timer = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bomb_game_ctrl.md
Name: bomb_game_ctrl

Overview:
- Top-level game sequencer for the bomb puzzle.
- Owns the 8-bit game_state bus that the countdown timer and puzzle modules observe.
- Selects and drives the timer's initial time from a difficulty setting, and aggregates per-module solved and strike signals.
- Decides defuse (win) or explosion (loss) and holds the result until the player restarts.

Parameters:
- N_MOD, 4, number of puzzle modules.
- MAX_STRIKES, 3, strike count that detonates the bomb; range 1..3.
- TIME_EASY, 12'h300, BCD initial time for difficulty 0.
- TIME_MED, 12'h200, BCD initial time for difficulty 1.
- TIME_HARD, 12'h090, BCD initial time for difficulty 2 and 3.

Ports:
- clk  in  1  on-board 50 MHz clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse from the debounced start button
- difficulty  in  2  difficulty select; sampled only on start in IDLE
- module_en  in  N_MOD  modules in play; sampled only on start in IDLE
- module_solved  in  N_MOD  level flags, 1 = module defused
- strike  in  N_MOD  one-cycle strike pulses, one bit per module
- sec_timer  in  1  one-second pulse, the same pulse that feeds the countdown
- value_three, value_two, value_one  in  4 each  BCD digits from the countdown
- game_state  out  8  8'h00 idle, 8'h10 active, 8'h20 defused, 8'h30 exploded
- init_time  out  12  BCD start time presented to the countdown
- strike_count  out  2  strikes so far, saturating
- strike_flash  out  1  one-cycle pulse per cycle in which any strike is accepted

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE, game_state 8'h00, strike_count 0, strike_flash 0.
  - init_time = TIME_EASY; latched enable mask = all ones.
- All outputs are registered; game_state is a direct decode of the state register.
- IDLE:
  - On start: latch module_en into en_q and latch init_time from difficulty (0→EASY, 1→MED, else HARD).
  - Also clear strike_count and go to ACTIVE. game_state reads 8'h10 the following cycle.
  - If module_en is all zero on start: latch all ones instead.
- ACTIVE, checks evaluated every cycle:
  - expire = sec_timer & (value_three, value_two, value_one all 0) & not first_cycle. first_cycle is a 1-cycle flag set on entry, because the timer still shows 999 until it loads.
  - nstrike = popcount(strike & en_q). Strikes from disabled modules are ignored.
  - sum = strike_count + nstrike, saturated at MAX_STRIKES. strike_count <= sum.
  - strike_flash = (nstrike != 0).
  - boom = expire | (sum >= MAX_STRIKES).
  - win = ((module_solved & en_q) == en_q).
  - Priority: boom → EXPLODED; else win → DEFUSED; else stay ACTIVE. A simultaneous final strike and last solve is an explosion.
  - start is ignored in ACTIVE.
- DEFUSED and EXPLODED:
  - Hold game_state, strike_count and init_time.
  - strike and sec_timer are ignored; strike_flash is 0.
  - start → IDLE, clearing strike_count. A second start is needed to play again.
- The countdown reverts to its own init when it sees 8'h20/8'h30. No other handshake exists with it.
- Reset mid-game: return to IDLE on the next edge regardless of state. Inputs sampled in that cycle are discarded.
- Digits are only compared for all-zero. Digit ordering inside init_time is passed through untouched.
- Unreachable state encodings recover to IDLE.

Decomposition:
- Shared package holds:
  - game_state encodings GS_IDLE = 8'h00, GS_ACTIVE = 8'h10, GS_DEFUSED = 8'h20, GS_EXPLODED = 8'h30;
  - the difficulty-to-time constants;
  - the state enum.
- These encodings are the single source for every module that decodes game_state.
- One natural sub-module: strike_counter. It takes strike & en_q, takes a clear input, performs the saturating popcount accumulate, and produces strike_count, strike_flash and the at-max flag.
- The FSM stays in bomb_game_ctrl.

Test Plan:
- Reset, then start with difficulty = 1 and module_en = 4'b0011 → next cycle game_state = 8'h10, init_time = 12'h200; raise module_solved = 4'b0011 → game_state = 8'h20 one cycle later.
- Active game; pulse strike = 4'b0001 three times on separate cycles → strike_count 1, 2, then 3 with game_state = 8'h30; strike_flash high exactly 3 cycles.
- Active game; pulse strike = 4'b1101 with module_en = 4'b0101 → strike_count = 2 in one cycle; a further strike = 4'b1000 is ignored.
- Digits 0/0/0 with sec_timer in the first ACTIVE cycle → no explosion; digits 0/0/0 with sec_timer later → 8'h30.
- Same cycle: last module solved plus expiry → 8'h30, not 8'h20. Then start → 8'h00 with strike_count 0; start again → 8'h10.
- Assert reset during ACTIVE with strike_count = 2 → next cycle game_state = 8'h00, strike_count = 0, init_time = 12'h300.
